// File: rtl/embed_mem_tester_pkg.sv
// Shared encodings and LFSR helpers for the embedded memory self-test master.
package embed_mem_tester_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_CHECK = 2'b10;
    localparam logic [1:0] OP_BOTH  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CHECK,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    localparam logic [31:0] LFSR_TAPS     = 32'h80200003;
    localparam logic [31:0] SEED_FALLBACK = 32'h00000001;

    // Galois right-shift step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/embed_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance.
module embed_lfsr32
    import embed_mem_tester_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        advance_i,
    output logic [31:0] q_o
);

    logic [31:0] q_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= load_val_i;
        end else if (advance_i) begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/embed_mem_tester.sv
// Avalon-MM master that fills a RAM window with an LFSR pattern and/or reads it back,
// counting mismatches and recording the first failing word address.
module embed_mem_tester
    import embed_mem_tester_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [ADDR_W:0]       word_count_i,
    input  logic [31:0]           seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           err_count_o,
    output logic                  first_err_valid_o,
    output logic [ADDR_W-1:0]     first_err_addr_o,
    output logic [ADDR_W-1:0]     avm_address_o,
    output logic [DATA_W/8-1:0]   avm_byteenable_o,
    output logic                  avm_chipselect_o,
    output logic                  avm_write_o,
    output logic [DATA_W-1:0]     avm_writedata_o,
    output logic                  avm_clken_o,
    input  logic [DATA_W-1:0]     avm_readdata_i
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam int              PIPE_W    = ADDR_W + DATA_W;

    state_t              state_q, state_d;
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         err_q, err_d;
    logic                fev_q, fev_d;
    logic [ADDR_W-1:0]   fea_q, fea_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [1:0]          op_q, op_d;
    logic [31:0]         seed_q, seed_d;

    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [PIPE_W-1:0]       pipe_q [READ_LATENCY];

    logic                lfsr_load;
    logic [31:0]         lfsr_load_val;
    logic                lfsr_adv;
    logic [31:0]         lfsr_q;
    logic [31:0]         seed_eff;
    logic [ADDR_W:0]     n_eff;
    logic                last_word;
    logic [ADDR_W-1:0]   pipe_addr;
    logic [DATA_W-1:0]   pipe_exp;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    embed_lfsr32 u_lfsr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (lfsr_load),
        .load_val_i (lfsr_load_val),
        .advance_i  (lfsr_adv),
        .q_o        (lfsr_q)
    );

    assign seed_eff  = (seed_i == 32'h0) ? SEED_FALLBACK : seed_i;
    assign n_eff     = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
    assign last_word = (idx_q == n_q - {{ADDR_W{1'b0}}, 1'b1});
    assign pipe_addr = pipe_q[READ_LATENCY-1][PIPE_W-1:DATA_W];
    assign pipe_exp  = pipe_q[READ_LATENCY-1][DATA_W-1:0];

    // The LFSR always holds the pattern for the access after the one on the bus,
    // so loads write the successor of the seed while the seed itself goes to pat.
    always_comb begin
        state_d       = state_q;
        cs_d          = cs_q;
        we_d          = we_q;
        addr_d        = addr_q;
        pat_d         = pat_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q;
        fev_d         = fev_q;
        fea_d         = fea_q;
        base_d        = base_q;
        n_d           = n_q;
        op_d          = op_q;
        seed_d        = seed_q;
        lfsr_load     = 1'b0;
        lfsr_load_val = lfsr_next(seed_q);
        lfsr_adv      = 1'b0;

        if (pipe_vld_q[READ_LATENCY-1] && (avm_readdata_i != pipe_exp)) begin
            err_d = sat_inc16(err_q);
            if (!fev_q) begin
                fev_d = 1'b1;
                fea_d = pipe_addr;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    seed_d = seed_eff;
                    base_d = base_addr_i;
                    n_d    = n_eff;
                    op_d   = op_i;
                    err_d  = '0;
                    fev_d  = 1'b0;
                    fea_d  = '0;
                    if (op_i == OP_NOP || n_eff == '0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = op_i[0] ? ST_FILL : ST_CHECK;
                        busy_d        = 1'b1;
                        cs_d          = 1'b1;
                        we_d          = op_i[0];
                        addr_d        = base_addr_i;
                        pat_d         = seed_eff;
                        idx_d         = '0;
                        lfsr_load     = 1'b1;
                        lfsr_load_val = lfsr_next(seed_eff);
                    end
                end
            end
            ST_FILL: begin
                if (last_word) begin
                    if (op_q == OP_BOTH) begin
                        state_d   = ST_CHECK;
                        we_d      = 1'b0;
                        addr_d    = base_q;
                        pat_d     = seed_q;
                        idx_d     = '0;
                        lfsr_load = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                        cs_d    = 1'b0;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    addr_d   = addr_q + 1'b1;
                    idx_d    = idx_q + 1'b1;
                    pat_d    = lfsr_q;
                    lfsr_adv = 1'b1;
                end
            end
            ST_CHECK: begin
                if (last_word) begin
                    state_d = ST_DRAIN;
                    cs_d    = 1'b0;
                    idx_d   = '0;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    idx_d    = idx_q + 1'b1;
                    pat_d    = lfsr_q;
                    lfsr_adv = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (idx_q == (ADDR_W+1)'(READ_LATENCY - 1)) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fea_q   <= '0;
            base_q  <= '0;
            n_q     <= '0;
            op_q    <= OP_NOP;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fea_q   <= fea_d;
            base_q  <= base_d;
            n_q     <= n_d;
            op_q    <= op_d;
            seed_q  <= seed_d;
        end
    end

    // Each read launches {address, expected} into the pipe, lining up with readdata.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_vld_q[0] <= cs_q & ~we_q;
            pipe_q[0]     <= {addr_q, pat_q};
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_q[k]     <= pipe_q[k-1];
            end
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_count_o       = err_q;
    assign first_err_valid_o = fev_q;
    assign first_err_addr_o  = fea_q;
    assign avm_address_o     = addr_q;
    assign avm_byteenable_o  = {(DATA_W/8){cs_q}};
    assign avm_chipselect_o  = cs_q;
    assign avm_write_o       = we_q;
    assign avm_writedata_o   = pat_q;
    assign avm_clken_o       = 1'b1;

endmodule

// File: doc/embed_mem_tester.md
# embed_mem_tester

Avalon-MM master that fills and/or verifies a single-port on-chip RAM slave (32-bit data, 12-bit word address, fixed read latency 1). It drives the slave's address, byteenable, chipselect, write, writedata and clken, and consumes readdata. It writes a 32-bit LFSR pattern over a programmable address window, reads the window back with one read per cycle, and reports the error count and the first failing address. It sits beside the Nios/fabric master in the embedded subsystem as a hardware memory self-test.

## Interface
- ADDR_W, 12, word address width of the slave
- DATA_W, 32, data width; byteenable width is DATA_W/8
- READ_LATENCY, 1, fixed cycles from read issue to valid readdata
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  01 fill, 10 check, 11 fill then check, 00 no-op
- base_addr  in  ADDR_W  first word address of the window
- word_count  in  ADDR_W+1  words in the window; values above 2^ADDR_W saturate to 2^ADDR_W
- seed  in  32  LFSR seed; 0 is replaced by 32'h1
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err_count  out  16  mismatching words, saturating at 16'hFFFF
- first_err_valid  out  1  at least one mismatch since start
- first_err_addr  out  ADDR_W  address of the first mismatch
- avm_address  out  ADDR_W  slave word address
- avm_byteenable  out  DATA_W/8  all ones whenever avm_chipselect=1, else 0
- avm_chipselect  out  1  access strobe
- avm_write  out  1  write qualifier
- avm_writedata  out  DATA_W  write data
- avm_clken  out  1  slave clock enable, constant 1
- avm_readdata  in  DATA_W  slave read data

## Operation
- States: IDLE, FILL, CHECK, DRAIN, FINISH.
- IDLE: start=1 loads the LFSR with seed, clears err_count, first_err_valid and first_err_addr, latches base_addr/word_count/op. op=01 or 11 goes to FILL; op=10 goes to CHECK; op=00 or word_count=0 goes straight to FINISH with no bus activity.
- FILL: one write per cycle with avm_address = base_addr + i (mod 2^ADDR_W, wraps), avm_writedata = LFSR state, LFSR advanced each cycle. After word i = N-1: if op=11, reload LFSR with seed and go to CHECK; otherwise go to FINISH.
- CHECK: one read per cycle (chipselect=1, write=0) over the same addresses. Expected data and address enter a READ_LATENCY-deep shift pipe. After the last read, go to DRAIN.
- DRAIN: READ_LATENCY cycles to collect outstanding data, then go to FINISH.
- Compare: when a pipe entry reaches the output, avm_readdata != expected increments err_count (saturating). On the first mismatch, first_err_addr is captured and first_err_valid is set.
- FINISH: done=1 for one cycle, busy=0; return to IDLE.
- LFSR: Galois right-shift, next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
- start while busy is ignored; results hold until the next accepted start.
- Reset at any time: state goes to IDLE, and all bus outputs, busy, done, err_count, first_err_* and the pipe are cleared asynchronously. avm_clken stays 1. Memory contents are not restored.

## Timing
- Reset values: every output 0 except avm_clken=1.
- All outputs are registered except avm_byteenable (decoded from avm_chipselect) and avm_clken.
- Fill of N words: start at cycle 0; writes on cycles 1..N; busy on 1..N; done on N+1.
- Check of N words: reads on cycles 1..N; data on 2..N+1; final err_count visible on N+2; done on N+2; busy on 1..N+1.
- Fill then check: reads on N+1..2N; done on 2N+2.
- Throughput: one access per cycle, with no idle cycle between FILL and CHECK.

## Structure
- Package embed_mem_tester_pkg holds:
  - op encoding constants
  - state enum
  - LFSR tap mask 32'h80200003
  - seed fallback 32'h1
- Sub-module embed_lfsr32 has ports clk, reset, load, load_val, advance, q. It is instantiated once; reload uses load.
- The compare pipe is inline, as a parameterised shift register of {addr, expected}.

## Test plan
- op=11, base=0, count=4, seed=1, ideal RAM model -> writes 0x00000001, 0x80200003, 0xC0300002, 0x60180001 at addresses 0..3; err_count=0; done on cycle 10.
- op=01, base=12'hFFE, count=4 -> write addresses FFE, FFF, 000, 001 (wrap); done on cycle 5.
- op=10 after a fill, with the model corrupting word 0x005 and 0x009, base=0, count=16 -> err_count=2, first_err_addr=0x005, first_err_valid=1.
- word_count=13'h1FFF, op=01 -> exactly 4096 writes; op=00 or count=0 -> done on cycle 1, no chipselect.
- start pulsed during FILL -> ignored; the original window completes unchanged. seed=0 -> first written word is 0x00000001.
- reset asserted on cycle 3 of a 16-word check -> chipselect, busy and err_count go to 0 immediately; no done pulse. The next start runs normally.
